// File: rtl/calc_alu_sched.sv
// Sequencer/arbiter for the 3-bit calculator ALU: round-robin grant between two
// requesters, 4x3 operand register file, IDLE->EXEC->WB with write-back.
module calc_alu_sched (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [1:0] req0_op,
    input  logic [1:0] req0_src1,
    input  logic [1:0] req0_src2,
    input  logic [1:0] req0_dst,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [1:0] req1_op,
    input  logic [1:0] req1_src1,
    input  logic [1:0] req1_src2,
    input  logic [1:0] req1_dst,
    input  logic       ld_en,
    input  logic [1:0] ld_addr,
    input  logic [2:0] ld_data,
    output logic [2:0] alu_in1,
    output logic [2:0] alu_in2,
    output logic [1:0] alu_c,
    input  logic [2:0] alu_out,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [2:0] rsp_data,
    output logic       busy,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic       last;
    logic       gnt_any, gnt_id, hs;
    logic [1:0] sel_op, sel_src1, sel_src2, sel_dst;
    logic [1:0] dst_q;
    logic       id_q;
    logic [2:0] result;
    logic [2:0] rf [4];

    // Handshake: a requester's operation is taken on any edge where its
    // valid and ready are both high; ready only exists in IDLE for the grantee.
    always_comb begin
        gnt_any    = req0_valid | req1_valid;
        gnt_id     = (req0_valid & req1_valid) ? ~last : req1_valid;
        hs         = (state == IDLE) & gnt_any;
        req0_ready = rst_n & hs & ~gnt_id;
        req1_ready = rst_n & hs & gnt_id;
        sel_op     = gnt_id ? req1_op   : req0_op;
        sel_src1   = gnt_id ? req1_src1 : req0_src1;
        sel_src2   = gnt_id ? req1_src2 : req0_src2;
        sel_dst    = gnt_id ? req1_dst  : req0_dst;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = hs ? EXEC : IDLE;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last    <= 1'b1;
            dst_q   <= '0;
            id_q    <= 1'b0;
            alu_in1 <= '0;
            alu_in2 <= '0;
            alu_c   <= '0;
            result  <= '0;
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else begin
            if (hs) begin
                dst_q   <= sel_dst;
                id_q    <= gnt_id;
                alu_in1 <= rf[sel_src1];
                alu_in2 <= rf[sel_src2];
                alu_c   <= sel_op;
                last    <= gnt_id;
            end
            if (state == EXEC) result <= alu_out;
            // Write-back is placed after the load so it wins on an address clash.
            if (ld_en) rf[ld_addr] <= ld_data;
            if (state == WB) rf[dst_q] <= result;
        end
    end

    assign rsp_valid = (state == WB);
    assign rsp_id    = rsp_valid & id_q;
    assign rsp_data  = rsp_valid ? result : 3'd0;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_calc_alu_sched.sv
// Randomized + directed bench for calc_alu_sched: external ALU model, register
// file reference model, expected-response queue checked by a negedge monitor.
module tb_calc_alu_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0] req0_op, req0_src1, req0_src2, req0_dst;
    logic [1:0] req1_op, req1_src1, req1_src2, req1_dst;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [2:0] ld_data;
    logic [2:0] alu_in1, alu_in2, alu_out, rsp_data;
    logic [1:0] alu_c, dbg_state;
    logic       rsp_valid, rsp_id, busy;

    int total = 0;
    int bad = 0;

    calc_alu_sched dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_dst(req0_dst),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_dst(req1_dst),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_c(alu_c), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference operation semantics in plain integer arithmetic, mod 8.
    function automatic logic [2:0] ref_op(logic [1:0] op, logic [2:0] a, logic [2:0] b);
        int r;
        case (op)
            2'd0:    r = (int'(a) + int'(b)) % 8;
            2'd1:    r = (int'(a) - int'(b) + 8) % 8;
            2'd2:    r = int'(a & b);
            default: r = int'(a ^ b);
        endcase
        return 3'(r);
    endfunction

    // External combinational ALU the block drives.
    always_comb alu_out = ref_op(alu_c, alu_in1, alu_in2);

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model + monitor state.
    logic [2:0]  mrf [4];
    int          wb_cd = 0;
    logic [1:0]  wb_dst;
    logic [2:0]  wb_res;
    logic        mlast = 1'b1;
    int          cyc = 0;
    logic        chk_alu = 1'b0;
    logic [2:0]  ea1, ea2;
    logic [1:0]  ec;
    logic [19:0] exp_q [$];
    logic        id_log [$];
    logic [2:0]  last_rsp_data;
    logic        last_rsp_id;

    always @(negedge clk) begin : model
        logic        idle, any, g, e0, e1, hs;
        logic [19:0] e;
        logic [1:0]  op, s1, s2, d;
        logic [2:0]  res;
        if (!rst_n) begin
            check("reset_outs", {req0_ready, req1_ready, alu_in1, alu_in2, alu_c,
                                 rsp_valid, rsp_id, rsp_data, busy, dbg_state}, 0);
            for (int i = 0; i < 4; i++) mrf[i] = 3'd0;
            wb_cd = 0;
            mlast = 1'b1;
            chk_alu = 1'b0;
            exp_q.delete();
        end else begin
            cyc++;
            if (chk_alu) begin
                check("alu_in1", alu_in1, ea1);
                check("alu_in2", alu_in2, ea2);
                check("alu_c", alu_c, ec);
                chk_alu = 1'b0;
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_cycle", 32'(cyc), 32'(e[19:4]));
                    check("rsp_id", rsp_id, e[3]);
                    check("rsp_data", rsp_data, e[2:0]);
                end
                last_rsp_data = rsp_data;
                last_rsp_id = rsp_id;
                id_log.push_back(rsp_id);
            end
            idle = (wb_cd == 0);
            any  = req0_valid | req1_valid;
            g    = (req0_valid && req1_valid) ? !mlast : req1_valid;
            e0   = idle && any && !g;
            e1   = idle && any && g;
            check("ready", {req0_ready, req1_ready}, {e0, e1});
            check("busy", busy, !idle);
            hs = e0 | e1;
            op = g ? req1_op : req0_op;
            s1 = g ? req1_src1 : req0_src1;
            s2 = g ? req1_src2 : req0_src2;
            d  = g ? req1_dst : req0_dst;
            res = 3'd0;
            if (hs) begin
                ea1 = mrf[s1];
                ea2 = mrf[s2];
                ec  = op;
                res = ref_op(op, ea1, ea2);
                exp_q.push_back({16'(cyc + 2), g, res});
                mlast = g;
            end
            if (ld_en) mrf[ld_addr] = ld_data;
            if (wb_cd == 1) mrf[wb_dst] = wb_res;
            if (wb_cd > 0) wb_cd--;
            if (hs) begin
                wb_cd = 2;
                wb_dst = d;
                wb_res = res;
                chk_alu = 1'b1;
            end
        end
    end

    task automatic set_req(int id, logic v, logic [1:0] op, logic [1:0] s1,
                           logic [1:0] s2, logic [1:0] d);
        if (id == 0) begin
            req0_valid = v; req0_op = op; req0_src1 = s1; req0_src2 = s2; req0_dst = d;
        end else begin
            req1_valid = v; req1_op = op; req1_src1 = s1; req1_src2 = s2; req1_dst = d;
        end
    endtask

    task automatic wait_ready(int id);
        int n = 0;
        forever begin
            @(negedge clk);
            if ((id == 0) ? req0_ready : req1_ready) break;
            n++;
            if (n > 20) begin
                check("ready_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic do_req(int id, logic [1:0] op, logic [1:0] s1, logic [1:0] s2,
                          logic [1:0] d);
        @(posedge clk); #1;
        set_req(id, 1'b1, op, s1, s2, d);
        wait_ready(id);
        @(posedge clk); #1;
        set_req(id, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    endtask

    task automatic ld(logic [1:0] a, logic [2:0] d);
        @(posedge clk); #1;
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check("rsp_timeout", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic arb_exp [4];
        logic r0, r1;
        arb_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
        set_req(0, 1'b1, 2'd0, 2'd0, 2'd1, 2'd2);
        set_req(1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        ld_en = 1'b0; ld_addr = 2'd0; ld_data = 3'd0;
        repeat (3) @(negedge clk);
        req0_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset while an operation is in EXEC: it must vanish.
        ld(2'd0, 3'd3);
        ld(2'd1, 3'd4);
        do_req(0, 2'd0, 2'd0, 2'd1, 2'd2);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        do_req(0, 2'd2, 2'd2, 2'd2, 2'd3);
        wait_rsp();
        check("rst_readback_rf2", last_rsp_data, 0);
        do_req(1, 2'd3, 2'd0, 2'd1, 2'd0);
        wait_rsp();
        check("rst_readback_rf01", last_rsp_data, 0);

        // Add wrap: 3 + 5 = 0 mod 8.
        ld(2'd0, 3'd3);
        ld(2'd1, 3'd5);
        do_req(0, 2'd0, 2'd0, 2'd1, 2'd2);
        wait_rsp();
        check("add_wrap", last_rsp_data, 0);
        check("add_wrap_id", last_rsp_id, 0);

        // Sub borrow: 2 - 5 = 5 mod 8.
        ld(2'd0, 3'd2);
        ld(2'd1, 3'd5);
        do_req(1, 2'd1, 2'd0, 2'd1, 2'd3);
        wait_rsp();
        check("sub_borrow", last_rsp_data, 5);
        check("sub_borrow_id", last_rsp_id, 1);

        // Both requesters contending: grants alternate.
        id_log.delete();
        fork
            begin
                do_req(0, 2'd3, 2'd0, 2'd1, 2'd2);
                do_req(0, 2'd3, 2'd1, 2'd2, 2'd3);
            end
            begin
                do_req(1, 2'd2, 2'd2, 2'd3, 2'd0);
                do_req(1, 2'd2, 2'd3, 2'd1, 2'd1);
            end
        join
        wait_rsp();
        check("arb_count", 32'(id_log.size()), 4);
        for (int i = 0; i < 4 && i < id_log.size(); i++)
            check("arb_seq", id_log[i], arb_exp[i]);

        // Write-back vs load on the same address: write-back wins.
        ld(2'd0, 3'd2);
        ld(2'd1, 3'd4);
        do_req(0, 2'd0, 2'd0, 2'd1, 2'd3);
        ld(2'd3, 3'd1);
        wait_rsp();
        do_req(0, 2'd2, 2'd3, 2'd3, 2'd0);
        wait_rsp();
        check("collision_rf3", last_rsp_data, 6);
        // Load to another address during write-back still lands.
        do_req(1, 2'd0, 2'd0, 2'd0, 2'd3);
        ld(2'd1, 3'd5);
        wait_rsp();
        do_req(1, 2'd2, 2'd1, 2'd1, 2'd2);
        wait_rsp();
        check("ld_other_rf1", last_rsp_data, 5);

        // Dependent back-to-back operation sees the written value.
        ld(2'd0, 3'd3);
        ld(2'd1, 3'd4);
        do_req(0, 2'd0, 2'd0, 2'd1, 2'd2);
        do_req(1, 2'd2, 2'd2, 2'd2, 2'd3);
        check("dep_alu_in1", alu_in1, 7);
        wait_rsp();
        check("dep_result", last_rsp_data, 7);

        // Randomized traffic with concurrent loads.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk); #1;
            r0 = req0_valid & req0_ready;
            r1 = req1_valid & req1_ready;
            @(posedge clk); #1;
            if (r0) req0_valid = 1'b0;
            if (r1) req1_valid = 1'b0;
            if (!req0_valid && $urandom_range(0, 1) == 1)
                set_req(0, 1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                        2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            if (!req1_valid && $urandom_range(0, 1) == 1)
                set_req(1, 1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                        2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            ld_en   = ($urandom_range(0, 3) == 0);
            ld_addr = 2'($urandom_range(0, 3));
            ld_data = 3'($urandom_range(0, 7));
        end
        @(negedge clk); #1;
        r0 = req0_valid & req0_ready;
        r1 = req1_valid & req1_ready;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        ld_en = 1'b0;
        wait_rsp();
        repeat (4) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
